// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors
// and an elaboration-time ceiling-log2 helper for sizing pointers.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 32'sd0;
    localparam int FIFO_MODE_FWFT = 32'sd1;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. Contents are intentionally never reset.
module fifo_sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/empty levels,
// occupancy count, overflow/underflow pulses and standard or FWFT read mode.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    parameter  int FWFT      = FIFO_MODE_STD,
    localparam int AW        = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic [AW:0]       data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   CNT_AE    = (AW+1)'(AE_THRESH);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // Reject illegal parameter combinations at elaboration.
    if (DATA_W < 1) begin : g_bad_width
        $error("fifo_sync_prog: DATA_W must be >= 1");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_prog: DEPTH must be a power of two >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("fifo_sync_prog: AF_THRESH out of range 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_prog: AE_THRESH out of range 0..DEPTH-1");
    end
    if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
        $error("fifo_sync_prog: FWFT must be 0 or 1");
    end

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [DATA_W-1:0] ram_q_s;

    // Flags decode the registered count, so acceptance uses this cycle's flags.
    assign full         = (count_r == CNT_DEPTH);
    assign almost_full  = (count_r >= CNT_AF);
    assign empty        = (count_r == CNT_ZERO);
    assign almost_empty = (count_r <= CNT_AE);
    assign data_count   = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    assign wr_acc_s = wr_en & ~full;
    assign rd_acc_s = rd_en & ~empty;

    // Pointer, occupancy and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= wr_en & full;
            underflow_r <= rd_en & empty;
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data),
        .raddr (rd_ptr_r),
        .rdata (ram_q_s)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; meaningless while empty.
        assign rd_data = ram_q_s;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_r;

        // Capture the head word on each accepted read, hold otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_r <= {DATA_W{1'b0}};
            end else if (rd_acc_s) begin
                rd_data_r <= ram_q_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end

        assign rd_data = rd_data_r;
    end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed self-checking bench: a standard-mode and an FWFT-mode FIFO, with
// a queue scoreboard holding the words expected back from the standard FIFO.
module tb_fifo_sync_prog;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [4:0] data_count;

    logic       rst_f, wr_en_f, rd_en_f;
    logic [7:0] wr_data_f;
    logic [7:0] rd_data_f;
    logic       full_f, almost_full_f, empty_f, almost_empty_f, overflow_f, underflow_f;
    logic [4:0] data_count_f;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .data_count(data_count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_prog #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst_f), .wr_en(wr_en_f), .wr_data(wr_data_f), .rd_en(rd_en_f),
        .rd_data(rd_data_f), .full(full_f), .almost_full(almost_full_f), .empty(empty_f),
        .almost_empty(almost_empty_f), .data_count(data_count_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, ".count"}, 32'(data_count), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 16));
        chk({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 14));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 2));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        rst_f = 1'b1; wr_en_f = 1'b0; rd_en_f = 1'b0; wr_data_f = 8'h00;

        // Reset
        cyc(); cyc();
        chk_flags("reset", 0);
        chk("reset.ovf", 32'(overflow), 32'd0);
        chk("reset.unf", 32'(underflow), 32'd0);
        chk("reset.rd_data", 32'(rd_data), 32'd0);
        chk("reset.fwft_empty", 32'(empty_f), 32'd1);
        rst = 1'b0; rst_f = 1'b0;

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); sb_q.push_back(8'(i));
            cyc();
            chk_flags($sformatf("fill%0d", i), i + 1);
        end

        // Overflow: dropped write
        wr_data = 8'hAA;
        cyc();
        chk("ovf.pulse", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(data_count), 32'd16);
        wr_en = 1'b0;
        cyc();
        chk("ovf.clear", 32'(overflow), 32'd0);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            exp_d = sb_q.pop_front();
            cyc();
            chk($sformatf("drain%0d.data", i), 32'(rd_data), 32'(exp_d));
            chk_flags($sformatf("drain%0d", i), 15 - i);
        end

        // Underflow: dropped read, output holds
        cyc();
        chk("unf.pulse", 32'(underflow), 32'd1);
        chk("unf.count", 32'(data_count), 32'd0);
        chk("unf.hold", 32'(rd_data), 32'h0F);
        rd_en = 1'b0;
        cyc();
        chk("unf.clear", 32'(underflow), 32'd0);

        // Preload five, then simultaneous traffic across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i); sb_q.push_back(wr_data);
            cyc();
        end
        chk_flags("pre5", 5);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 8'h40 + 8'(k); sb_q.push_back(wr_data);
            exp_d = sb_q.pop_front();
            cyc();
            chk($sformatf("simul%0d.data", k), 32'(rd_data), 32'(exp_d));
            chk($sformatf("simul%0d.count", k), 32'(data_count), 32'd5);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_d = sb_q.pop_front();
            cyc();
            chk($sformatf("tail%0d.data", i), 32'(rd_data), 32'(exp_d));
        end
        rd_en = 1'b0;
        cyc();
        chk_flags("tail_end", 0);

        // Both requests while empty: write only, underflow
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77; sb_q.push_back(8'h77);
        cyc();
        chk_flags("both_empty", 1);
        chk("both_empty.unf", 32'(underflow), 32'd1);
        rd_en = 1'b0;

        // Grow to nine, then reset while writing
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h50 + 8'(i); sb_q.push_back(wr_data);
            cyc();
        end
        chk_flags("pre_rst", 9);
        rst = 1'b1; wr_data = 8'hEE;
        cyc();
        sb_q.delete();
        chk_flags("mid_rst", 0);
        chk("mid_rst.rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        cyc();
        chk_flags("post_rst", 0);
        wr_en = 1'b1; wr_data = 8'h12; sb_q.push_back(8'h12);
        cyc();
        wr_en = 1'b0; rd_en = 1'b1;
        exp_d = sb_q.pop_front();
        cyc();
        chk("post_rst.data", 32'(rd_data), 32'(exp_d));
        chk_flags("post_rst_drain", 0);
        rd_en = 1'b0;

        // FWFT: word visible without a read, pop empties
        wr_en_f = 1'b1; wr_data_f = 8'h5A;
        cyc();
        wr_en_f = 1'b0;
        chk("fwft.empty", 32'(empty_f), 32'd0);
        chk("fwft.data", 32'(rd_data_f), 32'h5A);
        cyc();
        chk("fwft.hold", 32'(rd_data_f), 32'h5A);
        rd_en_f = 1'b1;
        cyc();
        rd_en_f = 1'b0;
        chk("fwft.pop_empty", 32'(empty_f), 32'd1);
        chk("fwft.pop_count", 32'(data_count_f), 32'd0);
        chk("fwft.unf", 32'(underflow_f), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
